// File: rtl/immgen_pkg.sv
// Shared opcode constants and immediate format codes for the immediate-generation stage.
package immgen_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_CSRZ  = 3'd7
    } imm_fmt_e;

    // slli/srli/srai share funct3[1:0]=01; the arithmetic bit lives in the immediate field.
    function automatic logic is_shift(input logic [2:0] funct3);
        return funct3[1:0] == 2'b01;
    endfunction

endpackage

// File: rtl/immgen_decode.sv
// Combinational immediate decoder: extracts and extends the immediate, classifies the format,
// and flags unrecognised opcodes.
module immgen_decode
    import immgen_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int EN_ZICSR = 1
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    localparam bit RV64 = (XLEN == 64);

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (inst[6:0])
            OPC_LOAD, OPC_JALR: begin
                fmt = FMT_I;
                imm = sext(imm_i);
            end
            OPC_OP_IMM: begin
                if (is_shift(inst[14:12])) begin
                    fmt = FMT_SHAMT;
                    imm = RV64 ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
                end else begin
                    fmt = FMT_I;
                    imm = sext(imm_i);
                end
            end
            OPC_OP_IMM32: begin
                if (!RV64) begin
                    illegal = 1'b1;
                end else if (is_shift(inst[14:12])) begin
                    fmt = FMT_SHAMT;
                    imm = XLEN'(inst[24:20]);
                end else begin
                    fmt = FMT_I;
                    imm = sext(imm_i);
                end
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = sext(imm_s);
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = sext(imm_b);
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = sext(imm_j);
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = sext(imm_u);
            end
            OPC_SYSTEM: begin
                if (EN_ZICSR != 0 && inst[14]) begin
                    fmt = FMT_CSRZ;
                    imm = XLEN'(inst[19:15]);
                end
            end
            OPC_OP, OPC_MISC_MEM: ;
            OPC_OP32: illegal = !RV64;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/immgen_stage.sv
// Registered immediate-generation stage: decoder feeding a one-cycle output register backed by a
// skid entry, so upstream ready is a flop and streaming runs without bubbles.
module immgen_stage
    import immgen_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 32,
    parameter int EN_ZICSR = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_inst,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_inst,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_fmt,
    output logic             o_illegal,
    output logic [TAG_W-1:0] o_tag
);

    typedef struct packed {
        logic [31:0]      inst;
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;
    entry_t          in_entry, out_q, skid_q;
    logic            out_valid_q, skid_valid_q;
    logic            accept, out_load, skid_load;

    immgen_decode #(.XLEN(XLEN), .EN_ZICSR(EN_ZICSR)) u_decode (
        .inst    (i_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign in_entry  = '{inst: i_inst, imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: i_tag};
    assign accept    = i_valid & ~skid_valid_q;
    assign out_load  = ~out_valid_q | i_ready;
    assign skid_load = accept & out_valid_q & ~i_ready;

    // NOTE: all state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
        end else if (i_flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            if (out_load) begin
                if (skid_valid_q) begin
                    out_q        <= skid_q;
                    out_valid_q  <= 1'b1;
                    skid_valid_q <= 1'b0;
                end else if (accept) begin
                    out_q       <= in_entry;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
            if (skid_load) skid_valid_q <= 1'b1;
        end
    end

    // NOTE: the skid payload has no reset; it is only ever read while skid_valid_q is set.
    always_ff @(posedge i_clk) begin
        if (skid_load) skid_q <= in_entry;
    end

    assign o_ready   = ~skid_valid_q;
    assign o_valid   = out_valid_q;
    assign o_inst    = out_q.inst;
    assign o_imm     = out_q.imm;
    assign o_fmt     = out_q.fmt;
    assign o_illegal = out_q.illegal;
    assign o_tag     = out_q.tag;

endmodule

// File: doc/immgen_stage.md
Name: immgen_stage

Overview:
- Registered, parametrised immediate-generation stage between fetch and decode/execute in the pipelined RV core.
- Generalises the single-cycle immediate generator:
  - XLEN 32 or 64.
  - Shift-amount and CSR zero-extended formats.
  - Illegal-opcode flag and format code.
  - Valid/ready handshake through a 2-entry skid buffer, with flush.
- Carries a side-band tag (PC or ROB id) aligned with each result.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
TAG_W, 32, width of the pass-through tag
EN_ZICSR, 1, 1 enables FMT_CSRZ decode; 0 treats SYSTEM as FMT_NONE

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_flush  in  1  synchronous flush; clears both buffer entries
i_valid  in  1  upstream has an instruction
o_ready  out  1  stage can accept; equals NOT skid_valid (registered)
i_inst  in  32  instruction word
i_tag  in  TAG_W  side-band tag
o_valid  out  1  output entry valid
i_ready  in  1  downstream accepts
o_inst  out  32  instruction of output entry
o_imm  out  XLEN  immediate of output entry
o_fmt  out  3  format code (see package)
o_illegal  out  1  opcode not recognised
o_tag  out  TAG_W  tag of output entry

Behaviour:
- Reset (async assert): o_valid=0, skid_valid=0 (so o_ready=1), o_inst=0, o_imm=0, o_fmt=FMT_NONE, o_illegal=0, o_tag=0.
- Latency: 1 cycle. Accept in cycle N appears on outputs in N+1 when the output register is free.
- Accept = i_valid & o_ready. Output transfer = o_valid & i_ready.
- Output register loads when empty or transferring:
  - from skid if skid_valid; otherwise
  - from the accepted input; otherwise it empties.
- Skid loads only when accept & o_valid & ~i_ready.
- Order is strictly FIFO. No bubble when both sides stream continuously.
- Output fields hold stable while o_valid & ~i_ready.
- i_flush has priority over everything:
  - next cycle o_valid=0, skid_valid=0, o_ready=1.
  - An input presented in the flush cycle is dropped.
  - Payload registers need not clear.
- Decode (combinational, registered on load), by opcode i_inst[6:0]:
  - Any of the rules below with i_inst[1:0]!=2'b11 -> illegal.
  - 0000011 LOAD, 1100111 JALR -> FMT_I.
  - 0010011 OP-IMM -> FMT_I. Exception: funct3 001/101 -> FMT_SHAMT, imm = zero-extended shamt (inst[24:20] for XLEN=32, inst[25:20] for XLEN=64).
  - 0011011 OP-IMM-32 (XLEN=64 only, else illegal) -> FMT_I; funct3 001/101 -> FMT_SHAMT with 5-bit shamt.
  - 0100011 -> FMT_S. 1100011 -> FMT_B with imm bit0=0. 1101111 -> FMT_J with bit0=0.
  - 0110111/0010111 -> FMT_U, imm = {inst[31:12],12'b0} sign-extended to XLEN.
  - 1110011 SYSTEM with funct3[2]=1 and EN_ZICSR=1 -> FMT_CSRZ, imm = zero-extended inst[19:15]. Otherwise FMT_NONE, imm 0.
  - 0110011, 0111011 (XLEN=64), 0001111 -> FMT_NONE, imm 0, legal.
  - Anything else -> FMT_NONE, imm 0, o_illegal=1.
- All I/S/B/J/U immediates are sign-extended from inst[31] to XLEN.

Decomposition:
- Package immgen_pkg:
  - Opcode localparams.
  - imm_fmt_e (3 bits): FMT_NONE=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_SHAMT=6, FMT_CSRZ=7.
- Sub-module immgen_decode:
  - Pure combinational; inputs inst, outputs imm/fmt/illegal.
  - Parametrised XLEN and EN_ZICSR.
  - Unit-testable alone.
- immgen_stage holds only the skid buffer and control.

Test Plan:
- XLEN=32, i_ready=1, i_inst=0xFFF00093 (addi -1) -> next cycle o_valid=1, o_imm=0xFFFFFFFF, o_fmt=1, o_illegal=0.
- i_inst=0xFE000EE3 (beq -4) -> o_imm=0xFFFFFFFC, fmt 3. i_inst=0x4030D093 (srai 3) -> o_imm=3, fmt 6. csrrwi zimm=5 -> o_imm=5, fmt 7.
- XLEN=64, i_inst=0x800000B7 (lui) -> o_imm=0xFFFFFFFF80000000, fmt 4. Opcode 0x7F -> o_illegal=1, o_imm=0.
- i_ready=0, three back-to-back valid inputs with tags 1, 2, 3:
  - o_ready falls after the second accept; the third is held upstream.
  - After i_ready=1, tags appear 1, 2, 3 on consecutive cycles, with no loss or duplication.
- Skid full, then assert i_flush with i_valid=1 -> next cycle o_valid=0, o_ready=1, and the flushed-cycle input never appears.
- Assert i_reset asynchronously mid-stream (between clock edges) -> o_valid=0, o_ready=1, o_fmt=0 immediately. After release, first accept emerges 1 cycle later.
